// File: rtl/wallace_unsigned_multiplier_cla_4.sv
// wallace_unsigned_multiplier_cla_4
// 4x4 unsigned multiplier with a registered 8-bit product.
//
// Datapath:
//   - 16 AND-gate partial products.
//   - Wallace tree of full adders that reduces them to two rows.
//   - 8-bit carry-lookahead adder made of two 4-bit lookahead blocks.
//     The lower block's group generate/propagate (G,P) supplies the
//     carry into the upper block.
//
// Optional build macro WALLACE_MUL_IN_REG_EN:
//   - Defined: A and B are registered before the core, so latency is 2 cycles.
//   - Undefined (default): latency is 1 cycle.
//   Throughput is one product per cycle in both builds.
//
// There is no handshake. Operands are sampled on every rising clk edge
// while rst_n is high, and product is valid one latency after sampling.
module wallace_unsigned_multiplier_cla_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] product
);

    // Full adder. Returns {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // 4-bit lookahead sum. Every carry is expanded from g/p and cin, with no ripple.
    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return p ^ {c3, c2, c1, cin};
    endfunction

    // Group {generate, propagate} of a 4-bit block.
    function automatic logic [1:0] cla4_gp(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g;
        logic [3:0] p;
        g = a & b;
        p = a ^ b;
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p};
    endfunction

    logic [3:0] op_a;
    logic [3:0] op_b;

`ifdef WALLACE_MUL_IN_REG_EN
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] a_d;
    logic [3:0] b_d;

    assign a_d = A;
    assign b_d = B;

    // Operand capture stage. Clears asynchronously with the product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 4'd0;
            b_q <= 4'd0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = A;
    assign op_b = B;
`endif

    // Partial products: pp[i][j] = A[j] & B[i], weight 2^(i+j).
    logic [3:0] pp [0:3];
    assign pp[0] = op_a & {4{op_b[0]}};
    assign pp[1] = op_a & {4{op_b[1]}};
    assign pp[2] = op_a & {4{op_b[2]}};
    assign pp[3] = op_a & {4{op_b[3]}};

    // Stage 1 reduces columns 2, 3 and 4.
    // Column 3 has four bits; pp[3][0] passes through to stage 2.
    logic [1:0] fa1_2;
    logic [1:0] fa1_3;
    logic [1:0] fa1_4;
    assign fa1_2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign fa1_3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    assign fa1_4 = fa(pp[1][3], pp[2][2], pp[3][1]);

    // Stage 2 reduces column 3 (passthrough + sum + carry from column 2)
    // and column 5 (two partial products + carry from column 4).
    logic [1:0] fa2_3;
    logic [1:0] fa2_5;
    assign fa2_3 = fa(pp[3][0], fa1_3[0], fa1_2[1]);
    assign fa2_5 = fa(pp[2][3], pp[3][2], fa1_4[1]);

    // Stage 3: column 4 now holds its stage-1 sum plus carries from stages 1 and 2.
    logic [1:0] fa3_4;
    assign fa3_4 = fa(fa1_4[0], fa1_3[1], fa2_3[1]);

    // Two reduced rows. Every column now holds at most two bits.
    logic [7:0] row_a;
    logic [7:0] row_b;
    assign row_a = {1'b0, pp[3][3], fa2_5[0], fa3_4[0], fa2_3[0], fa1_2[0], pp[0][1], pp[0][0]};
    assign row_b = {1'b0, fa2_5[1], fa3_4[1], 3'b000, pp[1][0], 1'b0};

    // Final CLA. The carry out of bit 7 is always 0, so it is not formed.
    logic       cin0;
    logic [1:0] gp_lo;
    logic       c4;
    logic [3:0] sum_lo;
    logic [3:0] sum_hi;
    logic [7:0] product_d;
    logic [7:0] product_q;

    assign cin0      = 1'b0;
    assign gp_lo     = cla4_gp(row_a[3:0], row_b[3:0]);
    assign c4        = gp_lo[1] | (gp_lo[0] & cin0);
    assign sum_lo    = cla4_sum(row_a[3:0], row_b[3:0], cin0);
    assign sum_hi    = cla4_sum(row_a[7:4], row_b[7:4], c4);
    assign product_d = {sum_hi, sum_lo};

    // Product register. Asynchronous clear keeps unknown operands off the output during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= 8'd0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_wallace_unsigned_multiplier_cla_4.sv
// Testbench for wallace_unsigned_multiplier_cla_4.
// Reference model: a latency queue of plain A*B products.
// The WALLACE_MUL_IN_REG_EN build is covered by defining the macro for both files.
module tb_wallace_unsigned_multiplier_cla_4;

`ifdef WALLACE_MUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_now;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[13];

    wallace_unsigned_multiplier_cla_4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .product (product)
    );

    // Clock block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clears the model. Input registers reset to 0, so the first outputs after release are 0*0.
    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(8'd0);
    endtask

    // Drives one operand pair and advances one clock, ending on the next negedge.
    // exp_now holds the model's expected product after that edge.
    task automatic cycle(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea;
        logic [7:0] eb;
        A  = a;
        B  = b;
        ea = {4'd0, a};
        eb = {4'd0, b};
        @(posedge clk);
        if (rst_n) begin
            exp_q.push_back(ea * eb);
            exp_now = exp_q.pop_front();
        end else begin
            model_reset();
            exp_now = 8'd0;
        end
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: product=%0d expected=%0d (A=%0d B=%0d t=%0t)",
                     nm, act, exp, A, B, $time);
        end
    endtask

    initial begin
        int n;

        vecs[0]  = '{4'd0,  4'd0,  8'd0,   "dir_0x0"};
        vecs[1]  = '{4'd2,  4'd3,  8'd6,   "dir_2x3"};
        vecs[2]  = '{4'd10, 4'd3,  8'd30,  "dir_10x3"};
        vecs[3]  = '{4'd13, 4'd10, 8'd130, "dir_13x10"};
        vecs[4]  = '{4'd15, 4'd15, 8'd225, "ext_15x15"};
        vecs[5]  = '{4'd15, 4'd1,  8'd15,  "ext_15x1"};
        vecs[6]  = '{4'd1,  4'd15, 8'd15,  "ext_1x15"};
        vecs[7]  = '{4'd0,  4'd15, 8'd0,   "ext_0x15"};
        vecs[8]  = '{4'd15, 4'd0,  8'd0,   "ext_15x0"};
        vecs[9]  = '{4'd8,  4'd2,  8'd16,  "cla_8x2"};
        vecs[10] = '{4'd9,  4'd7,  8'd63,  "cla_9x7"};
        vecs[11] = '{4'd12, 4'd12, 8'd144, "cla_12x12"};
        vecs[12] = '{4'd11, 4'd13, 8'd143, "cla_11x13"};
        n = 13;

        // Reset is asserted with a real falling edge before any clock edge.
        rst_n   = 1'b1;
        A       = 4'd13;
        B       = 4'd10;
        exp_now = 8'd0;
        #1 rst_n = 1'b0;
        #1 check("reset_immediate", product, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle(4'd13, 4'd10);
            check("reset_hold", product, 8'd0);
        end

        // Release reset and hold 13x10. The first 130 must appear after exactly LAT edges.
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            cycle(4'd13, 4'd10);
            if (i < LAT - 1) check("release_early", product, 8'd0);
        end
        check("release_130", product, 8'd130);

        // Directed table, pipelined one vector per cycle. Results are checked at latency LAT.
        for (int i = 0; i < n + LAT - 1; i++) begin
            int k;
            k = (i < n) ? i : n - 1;
            cycle(vecs[k].a, vecs[k].b);
            if (i >= LAT - 1) check(vecs[i - LAT + 1].name, product, vecs[i - LAT + 1].exp);
        end

        // Mid-stream reset: assert between edges, expect an immediate clear, then resume.
        for (int i = 0; i < 4; i++) begin
            cycle(4'($urandom_range(15, 1)), 4'($urandom_range(15, 1)));
            check("pre_reset_stream", product, exp_now);
        end
        #2 rst_n = 1'b0;
        #1 check("async_clear", product, 8'd0);
        @(negedge clk);
        cycle(4'd7, 4'd9);
        check("midreset_hold", product, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            check("post_reset_stream", product, exp_now);
        end

        // Exhaustive stream of all 256 pairs, back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                cycle(4'(a), 4'(b));
                check("exhaustive", product, exp_now);
            end
        end

        // Random stream.
        for (int i = 0; i < 200; i++) begin
            cycle(4'($urandom), 4'($urandom));
            check("random", product, exp_now);
        end

        // Drain the pipeline.
        for (int i = 0; i < LAT; i++) begin
            cycle(4'd0, 4'd0);
            check("drain", product, exp_now);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wallace_unsigned_multiplier_cla_4.md
Name: wallace_unsigned_multiplier_cla_4

Overview:
4x4-bit unsigned multiplier. Partial products are reduced by a Wallace tree of half/full adders to two rows, and a carry-lookahead adder (CLA) produces the final sum. The 8-bit result is registered. The block is a leaf arithmetic unit in the fast-multiplier library, used as the base case and as a reference for wider Wallace/CLA multipliers.

Parameters:
none (fixed 4x4 operand widths; 8-bit result)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  4  unsigned multiplicand
B  input  4  unsigned multiplier
product  output  8  registered unsigned product A*B

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0: product=8'd0, forced immediately, without waiting for a clock edge.
- No handshake. A and B are sampled on every rising clk edge while rst_n=1. New operands may be applied every cycle; throughput is 1 product per cycle.
- Latency: product = A*B of operands present before rising edge N, visible after edge N (1 cycle).
- Arithmetic is exact unsigned: product = A*B, range 0..225. There is no overflow or truncation because the 8-bit result always fits.
- Datapath structure (required, not only functionally equivalent):
  - Partial products: pp[i][j] = A[j] & B[i], i,j in 0..3, weight 2^(i+j). That is 16 bits.
  - Wallace reduction: per weight column, group bits into full adders (3:2) and half adders (2:2) in successive stages until every column has at most 2 bits. Each adder's sum goes to the same column and its carry goes to column+1.
  - Final adder: 8-bit CLA on the two reduced rows, built from two 4-bit CLA blocks. Each block computes g=a&b and p=a^b, with lookahead carries c(k+1)=g(k)|p(k)&c(k) expanded (no ripple inside a block). Carry-in to bit 0 is 0.
  - The block-to-block carry uses group generate/propagate (G,P).
  - Carry out of bit 7 is always 0 and is discarded.
- Only product is registered; the reduction tree and CLA are purely combinational between the operand inputs and the product register.
- Reset deasserted mid-stream: the first valid product appears after the first rising edge following rst_n=1.
- Reset asserted mid-stream: product clears to 0 asynchronously. Any in-flight result is lost.
- X/Z on A or B must not propagate to product while rst_n=0.

Optional Feature:
Macro WALLACE_MUL_IN_REG_EN.
- When defined: A and B are captured into 4-bit input registers, which reset asynchronously to 0 with rst_n. The multiplier core operates on the registered operands, and product is registered as before. Latency is 2 cycles; throughput stays 1 per cycle.
- Not defined: no input registers; latency is 1 cycle as specified above.
- Reset value and arithmetic are identical in both builds.

Test Plan:
- Reset: rst_n=0 with A=4'd13, B=4'd10 -> product=0 immediately and across clock edges. Release rst_n -> product=130 one cycle later (two cycles with WALLACE_MUL_IN_REG_EN).
- Directed values, one per cycle, pipelined: (0,0)->0, (2,3)->6, (10,3)->30, (13,10)->130. Each result appears exactly one cycle after its operands.
- Extremes: (15,15)->225; (15,1)->15; (1,15)->15; (0,15)->0; (15,0)->0.
- Carry stress through the CLA block boundary: (8,2)->16, (9,7)->63, (12,12)->144, (11,13)->143.
- Mid-stream reset: drive a stream, assert rst_n low between clock edges -> product=0 asynchronously. Deassert -> results resume with the specified latency.
- Exhaustive: all 256 (A,B) pairs streamed back-to-back -> every product equals A*B at the specified latency, checked in both macro builds.
